irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Parametrised interrupt controller between raw interrupt sources (UART, OS timers, GPU frameDrawn, SPI nINT pins) and the B32P2 interrupt input, in the 50 MHz CPU domain.
- Replaces ad-hoc per-signal synchronisers and the fixed 8-bit interrupt vector.
- Provides per-channel synchronisation, edge/level mode, enable mask and pending latch.
- Presents one prioritised request to the CPU with an ack/end-of-interrupt handshake. Channel 0 has the highest priority.

Parameters:
- N_IRQ, 8, number of interrupt channels (2..32).
- ID_BITS, 3, width of the channel id output; must satisfy 2^ID_BITS >= N_IRQ.
- SYNC_STAGES, 2, synchroniser flop depth per channel (>= 2).

Ports:
- clk  in  1  CPU clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- irq_in  in  N_IRQ  raw interrupt sources, asynchronous, active high
- cfg_we  in  1  configuration write strobe, single cycle
- cfg_sel  in  2  0 = enable mask, 1 = mode (1 = edge, 0 = level), 2 = pending write-1-to-clear, 3 = overflow write-1-to-clear
- cfg_data  in  N_IRQ  configuration write data
- enable_q  out  N_IRQ  current enable mask
- pending_q  out  N_IRQ  current pending bits
- irq_overflow  out  N_IRQ  per-channel overflow flags (see Optional Feature)
- cpu_irq  out  1  interrupt request to CPU
- cpu_irq_id  out  ID_BITS  id of the requesting channel, valid while cpu_irq = 1
- cpu_ack  in  1  CPU accepts the request, single-cycle pulse
- cpu_eoi  in  1  CPU end of interrupt, single-cycle pulse

Behaviour:
- Reset (async assert, sync release) values:
  - synchronisers and edge-detect history = 0
  - enable = 0 (all channels masked); mode = all 1 (edge); pending = 0; overflow = 0
  - cpu_irq = 0; cpu_irq_id = 0; state = IDLE
- Synchroniser: SYNC_STAGES flops per channel, then one history flop for edge detection.
- Edge mode: a synced 0->1 transition sets pending[i].
  - Latency: pending_q[i] rises SYNC_STAGES+1 clk edges after irq_in[i] is first sampled high. A pulse shorter than 1 clk may be missed.
- Level mode: pending[i] is set every cycle the synced level is 1. It is cleared only by ack or W1C, and only when the synced level is 0 that cycle.
- Pending is latched regardless of enable. Masking hides a channel from arbitration but does not clear it.
- Simultaneous set and clear (ack or W1C) on the same channel in the same cycle: set wins.
- active = pending & enable. Selected channel = lowest-index set bit of active.
- State machine (all outputs registered):
  - IDLE: if active != 0, latch cpu_irq_id = selected channel, set cpu_irq = 1, go to REQ.
  - REQ: cpu_irq held at 1 and cpu_irq_id held stable, even if the source is masked or deasserted. On cpu_ack: clear pending[cpu_irq_id] (subject to the level and set-wins rules), cpu_irq = 0 next cycle, go to SERVICE.
  - SERVICE: no new request is issued. On cpu_eoi, go to IDLE; arbitration resumes the next cycle.
- Ack-to-request timing: minimum 2 cycles from cpu_eoi to the next cpu_irq rise.
- Out-of-state pulses are ignored: cpu_ack outside REQ, cpu_eoi outside SERVICE.
- cpu_ack and cpu_eoi asserted together in REQ: treated as ack only.
- Config writes take effect the next cycle.
  - A mode change does not alter existing pending bits.
  - A channel newly enabled with pending = 1 is requested from IDLE on the following cycle.
- Channels with index >= N_IRQ do not exist. cfg_data bits above N_IRQ-1 are not present.
- Reset mid-REQ or mid-SERVICE: cpu_irq drops asynchronously and the state returns to IDLE. Pending state is lost.

Optional Feature:
- Macro: IRQ_OVERFLOW_EN.
- Defined: overflow[i] is set when an edge-mode set event occurs while pending[i] is already 1, or while channel i is in REQ or SERVICE. Set wins over W1C. irq_overflow reflects the flags.
- Undefined: no overflow flops are built, irq_overflow is tied to 0, and cfg_sel = 3 writes are ignored.

Test Plan:
- Reset, enable = 0x01, mode = edge, pulse irq_in[0] high for 3 clk -> pending_q[0] = 1 at cycle SYNC_STAGES+1, cpu_irq = 1 and cpu_irq_id = 0 one cycle later; ack -> pending_q = 0x00, cpu_irq = 0; eoi -> IDLE.
- enable = 0xFF, raise irq_in[5] and irq_in[2] together -> cpu_irq_id = 2; ack + eoi -> cpu_irq_id = 5 two cycles after eoi.
- Level mode on channel 3, irq_in[3] held high through ack -> pending_q[3] stays 1 and the channel re-requests after eoi; drop irq_in[3] then ack -> pending clears.
- enable = 0x00, pulse irq_in[1] -> pending_q = 0x02, cpu_irq = 0; write enable = 0x02 -> cpu_irq = 1 and cpu_irq_id = 1 two cycles later.
- Edge on channel 4 arriving in the same cycle as a W1C of 0x10 -> pending_q[4] = 1. With IRQ_OVERFLOW_EN, a second edge while pending -> irq_overflow = 0x10; W1C via cfg_sel = 3 -> 0x00.
- Assert reset_n = 0 while in REQ -> cpu_irq = 0 immediately, enable_q = 0, pending_q = 0; after release, no request until a new edge arrives.

Source files
------------

// File: rtl/irq_controller.sv
// Prioritised interrupt controller: per-channel synchronisers, edge/level capture, enable mask, pending latch and a
// REQ/ack/EOI handshake to the CPU. Define IRQ_OVERFLOW_EN to build the per-channel overflow flags.
module irq_controller #(
  parameter int N_IRQ       = 8,
  parameter int ID_BITS     = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_IRQ-1:0]   irq_in,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_sel,
  input  logic [N_IRQ-1:0]   cfg_data,
  output logic [N_IRQ-1:0]   enable_q,
  output logic [N_IRQ-1:0]   pending_q,
  output logic [N_IRQ-1:0]   irq_overflow,
  output logic               cpu_irq,
  output logic [ID_BITS-1:0] cpu_irq_id,
  input  logic               cpu_ack,
  input  logic               cpu_eoi
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_IRQ-1:0]   sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0]   sync_d [SYNC_STAGES];
  logic [N_IRQ-1:0]   hist_q, hist_d;
  logic [N_IRQ-1:0]   mode_q, mode_d;
  logic [N_IRQ-1:0]   enable_d, pending_d;
  logic               cpu_irq_q, cpu_irq_d;
  logic [ID_BITS-1:0] cpu_irq_id_q, cpu_irq_id_d;

  logic [N_IRQ-1:0]   synced, edge_set, set_vec, active, ack_clr, w1c_pend;
  logic [ID_BITS-1:0] sel_id;
  logic               ack_fire;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign edge_set = mode_q & synced & ~hist_q;
  // Level channels re-set every cycle the synced input is high, so a clear only sticks once it is low.
  assign set_vec  = edge_set | (~mode_q & synced);
  assign active   = pending_q & enable_q;
  assign ack_fire = (state_q == ST_REQ) && cpu_ack;
  assign w1c_pend = (cfg_we && cfg_sel == 2'd2) ? cfg_data : '0;

  always_comb begin
    sync_d[0] = irq_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    hist_d = synced;
  end

  always_comb begin
    sel_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (active[i]) sel_id = ID_BITS'(i);
    end
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      ack_clr[i] = ack_fire && (cpu_irq_id_q == ID_BITS'(i));
    end
  end

  always_comb begin
    enable_d  = (cfg_we && cfg_sel == 2'd0) ? cfg_data : enable_q;
    mode_d    = (cfg_we && cfg_sel == 2'd1) ? cfg_data : mode_q;
    pending_d = set_vec | (pending_q & ~(ack_clr | w1c_pend));
  end

  always_comb begin
    state_d      = state_q;
    cpu_irq_d    = cpu_irq_q;
    cpu_irq_id_d = cpu_irq_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (active != '0) begin
          cpu_irq_d    = 1'b1;
          cpu_irq_id_d = sel_id;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (cpu_ack) begin
          cpu_irq_d = 1'b0;
          state_d   = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (cpu_eoi) state_d = ST_IDLE;
      end
      default: begin
        cpu_irq_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q       <= '0;
      mode_q       <= '1;
      enable_q     <= '0;
      pending_q    <= '0;
      cpu_irq_q    <= 1'b0;
      cpu_irq_id_q <= '0;
      state_q      <= ST_IDLE;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
      hist_q       <= hist_d;
      mode_q       <= mode_d;
      enable_q     <= enable_d;
      pending_q    <= pending_d;
      cpu_irq_q    <= cpu_irq_d;
      cpu_irq_id_q <= cpu_irq_id_d;
      state_q      <= state_d;
    end
  end

  assign cpu_irq    = cpu_irq_q;
  assign cpu_irq_id = cpu_irq_id_q;

`ifdef IRQ_OVERFLOW_EN
  logic [N_IRQ-1:0] ovf_q, ovf_d, busy_vec, w1c_ovf;

  assign w1c_ovf = (cfg_we && cfg_sel == 2'd3) ? cfg_data : '0;

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      busy_vec[i] = (state_q != ST_IDLE) && (cpu_irq_id_q == ID_BITS'(i));
    end
    ovf_d = (edge_set & (pending_q | busy_vec)) | (ovf_q & ~w1c_ovf);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf_q <= '0;
    else          ovf_q <= ovf_d;
  end

  assign irq_overflow = ovf_q;
`else
  assign irq_overflow = '0;
`endif

endmodule

// File: tb/tb_irq_controller.sv
// Directed, table-driven bench for irq_controller (N_IRQ=8, SYNC_STAGES=2) plus a hand-written reset-in-REQ sequence.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irq_in = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_sel = '0;
  logic [7:0] cfg_data = '0;
  logic [7:0] enable_q, pending_q, irq_overflow;
  logic       cpu_irq;
  logic [2:0] cpu_irq_id;
  logic       cpu_ack = 1'b0;
  logic       cpu_eoi = 1'b0;

  int checks = 0;
  int errors = 0;

`ifdef IRQ_OVERFLOW_EN
  localparam logic [7:0] OVF_EXP = 8'h10;
`else
  localparam logic [7:0] OVF_EXP = 8'h00;
`endif

  irq_controller #(.N_IRQ(8), .ID_BITS(3), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .irq_in       (irq_in),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_data     (cfg_data),
    .enable_q     (enable_q),
    .pending_q    (pending_q),
    .irq_overflow (irq_overflow),
    .cpu_irq      (cpu_irq),
    .cpu_irq_id   (cpu_irq_id),
    .cpu_ack      (cpu_ack),
    .cpu_eoi      (cpu_eoi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] irq;
    logic       we;
    logic [1:0] sel;
    logic [7:0] data;
    logic       ack;
    logic       eoi;
    logic [7:0] en;
    logic [7:0] pend;
    logic       req;
    logic [2:0] id;
    logic [7:0] ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] irq, input logic we, input logic [1:0] sel, input logic [7:0] data,
                     input logic ack, input logic eoi, input logic [7:0] en, input logic [7:0] pend,
                     input logic req, input logic [2:0] id, input logic [7:0] ovf);
    vec_t v;
    v.irq = irq; v.we = we; v.sel = sel; v.data = data; v.ack = ack; v.eoi = eoi;
    v.en = en; v.pend = pend; v.req = req; v.id = id; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    irq_in = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0; cpu_ack = 1'b0; cpu_eoi = 1'b0;
  endtask

  task automatic wait_req(input string name, input logic [2:0] exp_id);
    int n = 0;
    while (!cpu_irq && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " req"}, 32'(cpu_irq), 32'd1);
    chk({name, " id"}, 32'(cpu_irq_id), 32'(exp_id));
  endtask

  initial begin
    // irq, we, sel, data, ack, eoi | en, pend, req, id, ovf
    // Edge on ch0, 3-cycle pulse, full handshake
    add(8'h00, 1, 2'd0, 8'h01, 0, 0, 8'h01, 8'h00, 0, 0, 8'h00);
    add(8'h01, 0, 2'd0, 8'h00, 0, 0, 8'h01, 8'h00, 0, 0, 8'h00);
    add(8'h01, 0, 2'd0, 8'h00, 0, 0, 8'h01, 8'h00, 0, 0, 8'h00);
    add(8'h01, 0, 2'd0, 8'h00, 0, 0, 8'h01, 8'h01, 0, 0, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 0, 0, 8'h01, 8'h01, 1, 0, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 1, 0, 8'h01, 8'h00, 0, 0, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 0, 1, 8'h01, 8'h00, 0, 0, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 0, 0, 8'h01, 8'h00, 0, 0, 8'h00);
    // Priority: ch5 and ch2 together
    add(8'h00, 1, 2'd0, 8'hFF, 0, 0, 8'hFF, 8'h00, 0, 0, 8'h00);
    add(8'h24, 0, 2'd0, 8'h00, 0, 0, 8'hFF, 8'h00, 0, 0, 8'h00);
    add(8'h24, 0, 2'd0, 8'h00, 0, 0, 8'hFF, 8'h00, 0, 0, 8'h00);
    add(8'h24, 0, 2'd0, 8'h00, 0, 0, 8'hFF, 8'h24, 0, 0, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 0, 0, 8'hFF, 8'h24, 1, 2, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 1, 0, 8'hFF, 8'h20, 0, 0, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 0, 1, 8'hFF, 8'h20, 0, 0, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 0, 0, 8'hFF, 8'h20, 1, 5, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 1, 0, 8'hFF, 8'h00, 0, 0, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 0, 1, 8'hFF, 8'h00, 0, 0, 8'h00);
    // Level mode on ch3
    add(8'h00, 1, 2'd1, 8'hF7, 0, 0, 8'hFF, 8'h00, 0, 0, 8'h00);
    add(8'h08, 0, 2'd0, 8'h00, 0, 0, 8'hFF, 8'h00, 0, 0, 8'h00);
    add(8'h08, 0, 2'd0, 8'h00, 0, 0, 8'hFF, 8'h00, 0, 0, 8'h00);
    add(8'h08, 0, 2'd0, 8'h00, 0, 0, 8'hFF, 8'h08, 0, 0, 8'h00);
    add(8'h08, 0, 2'd0, 8'h00, 0, 0, 8'hFF, 8'h08, 1, 3, 8'h00);
    add(8'h08, 0, 2'd0, 8'h00, 1, 0, 8'hFF, 8'h08, 0, 0, 8'h00);
    add(8'h08, 0, 2'd0, 8'h00, 0, 1, 8'hFF, 8'h08, 0, 0, 8'h00);
    add(8'h08, 0, 2'd0, 8'h00, 0, 0, 8'hFF, 8'h08, 1, 3, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 0, 0, 8'hFF, 8'h08, 1, 3, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 0, 0, 8'hFF, 8'h08, 1, 3, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 1, 0, 8'hFF, 8'h00, 0, 0, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 0, 1, 8'hFF, 8'h00, 0, 0, 8'h00);
    add(8'h00, 1, 2'd1, 8'hFF, 0, 0, 8'hFF, 8'h00, 0, 0, 8'h00);
    // Masked pending, then enable
    add(8'h00, 1, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    add(8'h02, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    add(8'h02, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    add(8'h02, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h02, 0, 0, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 0, 0, 8'h00, 8'h02, 0, 0, 8'h00);
    add(8'h00, 1, 2'd0, 8'h02, 0, 0, 8'h02, 8'h02, 0, 0, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 0, 0, 8'h02, 8'h02, 1, 1, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 1, 0, 8'h02, 8'h00, 0, 0, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 0, 1, 8'h02, 8'h00, 0, 0, 8'h00);
    // Edge on ch4 colliding with W1C, then second edge while pending
    add(8'h10, 0, 2'd0, 8'h00, 0, 0, 8'h02, 8'h00, 0, 0, 8'h00);
    add(8'h10, 0, 2'd0, 8'h00, 0, 0, 8'h02, 8'h00, 0, 0, 8'h00);
    add(8'h10, 1, 2'd2, 8'h10, 0, 0, 8'h02, 8'h10, 0, 0, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 0, 0, 8'h02, 8'h10, 0, 0, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 0, 0, 8'h02, 8'h10, 0, 0, 8'h00);
    add(8'h00, 0, 2'd0, 8'h00, 0, 0, 8'h02, 8'h10, 0, 0, 8'h00);
    add(8'h10, 0, 2'd0, 8'h00, 0, 0, 8'h02, 8'h10, 0, 0, 8'h00);
    add(8'h10, 0, 2'd0, 8'h00, 0, 0, 8'h02, 8'h10, 0, 0, 8'h00);
    add(8'h10, 0, 2'd0, 8'h00, 0, 0, 8'h02, 8'h10, 0, 0, OVF_EXP);
    add(8'h00, 1, 2'd3, 8'h10, 0, 0, 8'h02, 8'h10, 0, 0, 8'h00);
    add(8'h00, 1, 2'd2, 8'h10, 0, 0, 8'h02, 8'h00, 0, 0, 8'h00);
    // Stray ack/eoi in IDLE are ignored
    add(8'h00, 0, 2'd0, 8'h00, 1, 1, 8'h02, 8'h00, 0, 0, 8'h00);

    // Clock/reset
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset enable", 32'(enable_q), 32'h00);
    chk("reset pending", 32'(pending_q), 32'h00);
    chk("reset cpu_irq", 32'(cpu_irq), 32'h0);
    chk("reset cpu_irq_id", 32'(cpu_irq_id), 32'h0);
    chk("reset overflow", 32'(irq_overflow), 32'h00);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      irq_in = vecs[k].irq; cfg_we = vecs[k].we; cfg_sel = vecs[k].sel; cfg_data = vecs[k].data;
      cpu_ack = vecs[k].ack; cpu_eoi = vecs[k].eoi;
      @(posedge clk); #1;
      chk($sformatf("row%0d enable", k), 32'(enable_q), 32'(vecs[k].en));
      chk($sformatf("row%0d pending", k), 32'(pending_q), 32'(vecs[k].pend));
      chk($sformatf("row%0d cpu_irq", k), 32'(cpu_irq), 32'(vecs[k].req));
      if (vecs[k].req) chk($sformatf("row%0d cpu_irq_id", k), 32'(cpu_irq_id), 32'(vecs[k].id));
      chk($sformatf("row%0d overflow", k), 32'(irq_overflow), 32'(vecs[k].ovf));
    end
    @(negedge clk);
    idle_inputs();

    // Reset while a request is outstanding
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); irq_in = 8'h02;
    end
    @(negedge clk); irq_in = 8'h00;
    wait_req("pre-reset", 3'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid-req reset cpu_irq", 32'(cpu_irq), 32'h0);
    chk("mid-req reset enable", 32'(enable_q), 32'h00);
    chk("mid-req reset pending", 32'(pending_q), 32'h00);
    @(negedge clk);
    reset_n = 1'b1;
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'h02;
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);
    chk("post-reset enable", 32'(enable_q), 32'h02);
    chk("post-reset no req", 32'(cpu_irq), 32'h0);
    chk("post-reset pending", 32'(pending_q), 32'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); irq_in = 8'h02;
    end
    @(negedge clk); irq_in = 8'h00;
    wait_req("post-reset edge", 3'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
